// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-port responder: word RAM, MMIO store-to-FIFO output queue, status word.
// Optional MMIO_READBACK_EN: status word readable at STATUS_ADDR, load of it clears overflow.
module data_mem_responder #(
    parameter int          MEM_WORDS   = 64,
    parameter logic [31:0] OUT_ADDR    = 32'h54,
    parameter logic [31:0] STATUS_ADDR = 32'h58,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          memwrite,
    input  logic                          memread,
    input  logic [31:0]                   dataaddr,
    input  logic [31:0]                   writedata,
    output logic [31:0]                   readdata,
    output logic                          out_valid,
    output logic [31:0]                   out_data,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          misalign
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] P_ONE  = PW'(1);
    localparam logic [31:0]   RAM_BYTES = 32'(4 * MEM_WORDS);

    logic [31:0]   r_mem [MEM_WORDS];
    logic [31:0]   r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_misalign;

    logic          w_aligned;
    logic          w_access;
    logic          w_hit_out;
    logic          w_hit_stat;
    logic          w_hit_ram;
    logic [AW-1:0] w_idx;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_push_ok;

    // Every decode hit requires word alignment, so misaligned accesses touch nothing.
    assign w_aligned  = (dataaddr[1:0] == 2'b00);
    assign w_access   = memwrite | memread;
    assign w_hit_out  = w_aligned & (dataaddr == OUT_ADDR);
    assign w_hit_stat = w_aligned & (dataaddr == STATUS_ADDR);
    assign w_hit_ram  = w_aligned & !w_hit_out & !w_hit_stat & (dataaddr < RAM_BYTES);
    assign w_idx      = dataaddr[AW+1:2];

    assign w_full    = (r_count == C_FULL);
    assign w_push    = memwrite & w_hit_out;
    assign w_pop     = out_valid & out_ready;
    assign w_push_ok = w_push & (!w_full | w_pop);

    assign out_valid  = (r_count != '0);
    assign out_data   = r_fifo[r_rd_ptr];
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign misalign   = r_misalign;

    always_comb begin
        readdata = 32'h0;
        if (memread & w_hit_ram)
            readdata = r_mem[w_idx];
`ifdef MMIO_READBACK_EN
        else if (memread & w_hit_stat)
            readdata = {16'h0, 8'(r_count), 6'h0, r_misalign, r_overflow};
`endif
    end

    always_ff @(posedge clk) begin
        if (memwrite & w_hit_ram)
            r_mem[w_idx] <= writedata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_misalign <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_fifo[i] <= 32'h0;
        end else begin
            if (w_push_ok) begin
                r_fifo[r_wr_ptr] <= writedata;
                r_wr_ptr         <= r_wr_ptr + P_ONE;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + P_ONE;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
            if (w_push & !w_push_ok)
                r_overflow <= 1'b1;
`ifdef MMIO_READBACK_EN
            else if (memread & w_hit_stat)
                r_overflow <= 1'b0;
`endif
            if (w_access & !w_aligned)
                r_misalign <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder.
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic        memread;
    logic [31:0] dataaddr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        misalign;

    int total = 0;
    int bad   = 0;

    data_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .memread    (memread),
        .dataaddr   (dataaddr),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataaddr  = a;
        writedata = d;
        cyc();
        memwrite  = 1'b0;
    endtask

    task automatic load_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        memread  = 1'b1;
        dataaddr = a;
        #1;
        check(tag, readdata, exp);
        memread  = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    logic [31:0] drain4 [4];

    initial begin
        reset = 1'b1; memwrite = 1'b0; memread = 1'b0;
        dataaddr = 32'h0; writedata = 32'h0; out_ready = 1'b0;
        cyc(); cyc();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        check("rst_mis",   32'(misalign), 32'd0);
        check("rst_data",  out_data, 32'h0);
        reset = 1'b0;
        cyc();

        // RAM store then load
        store(32'h14, 32'h0);
        store(32'h10, 32'd7);
        load_check("ld_10", 32'h10, 32'd7);
        load_check("ld_14", 32'h14, 32'd0);
        dataaddr = 32'h10; #1;
        check("ld_noread", readdata, 32'h0);
        store(32'h0, 32'h11);
        store(32'hFC, 32'hABCD);
        load_check("ld_last", 32'hFC, 32'hABCD);
        store(32'h100, 32'h55);
        load_check("ld_noalias", 32'h0, 32'h11);
        load_check("ld_oor", 32'h100, 32'h0);

        // single push, no bypass, then pop
        memwrite = 1'b1; dataaddr = 32'd84; writedata = 32'hFFFFFFFB; #1;
        check("nobypass", 32'(out_valid), 32'd0);
        cyc(); memwrite = 1'b0;
        check("push_valid", 32'(out_valid), 32'd1);
        check("push_data",  out_data, 32'hFFFFFFFB);
        check("push_count", 32'(fifo_count), 32'd1);
        load_check("ld_out", 32'd84, 32'h0);
        out_ready = 1'b1; cyc(); out_ready = 1'b0;
        check("pop_valid", 32'(out_valid), 32'd0);
        check("pop_count", 32'(fifo_count), 32'd0);

        // overflow after five pushes
        for (int i = 1; i <= 5; i++) store(32'd84, 32'(i));
        check("ovf_count", 32'(fifo_count), 32'd4);
        check("ovf_flag",  32'(overflow), 32'd1);
        cyc();
        check("hold_data", out_data, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_data", out_data, 32'(i));
            out_ready = 1'b1; cyc(); out_ready = 1'b0;
        end
        check("drain_empty", 32'(out_valid), 32'd0);

        // full with simultaneous push and pop
        pulse_reset();
        check("ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) store(32'd84, 32'(10 + i));
        out_ready = 1'b1;
        store(32'd84, 32'd9);
        out_ready = 1'b0;
        check("pp_count", 32'(fifo_count), 32'd4);
        check("pp_ovf",   32'(overflow), 32'd0);
        drain4[0] = 32'd11; drain4[1] = 32'd12; drain4[2] = 32'd13; drain4[3] = 32'd9;
        for (int i = 0; i < 4; i++) begin
            check("pp_data", out_data, drain4[i]);
            out_ready = 1'b1; cyc(); out_ready = 1'b0;
        end
        check("pp_empty", 32'(fifo_count), 32'd0);

        // misaligned accesses
        store(32'h13, 32'hDEAD);
        check("mis_flag", 32'(misalign), 32'd1);
        load_check("mis_ram", 32'h10, 32'd7);
        store(32'h55, 32'h77);
        check("mis_nopush", 32'(fifo_count), 32'd0);
        load_check("mis_ld", 32'h11, 32'h0);
        store(32'h58, 32'h66);
        check("stat_nopush", 32'(fifo_count), 32'd0);

        // status readback and reset mid-stream
        pulse_reset();
        check("mis_cleared", 32'(misalign), 32'd0);
        store(32'd84, 32'h21);
        store(32'd84, 32'h22);
`ifdef MMIO_READBACK_EN
        load_check("stat_rd", 32'h58, 32'h00000200);
`else
        load_check("stat_rd", 32'h58, 32'h0);
`endif
        store(32'd84, 32'h23);
        check("pre_count", 32'(fifo_count), 32'd3);
        reset = 1'b1; #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_count", 32'(fifo_count), 32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        check("arst_data", out_data, 32'h0);
        load_check("ram_kept", 32'h10, 32'd7);
        load_check("ram_kept2", 32'hFC, 32'hABCD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
